// File: rtl/beam_dac_conditioner.sv
// Beam coordinate to 12-bit DAC code conditioner with redundant-point suppression and a
// show-ahead point FIFO. Define BEAM_DAC_STATS_EN to build the overflow counter and watermark.
module beam_dac_conditioner #(
    parameter int H_CENTER    = 270,
    parameter int V_CENTER    = 360,
    parameter int SCALE_SHIFT = 1,
    parameter int DAC_MID     = 2047,
    parameter int MIN_DELTA   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_en,
    input  logic [9:0]                  beam_h,
    input  logic [9:0]                  beam_v,
    input  logic                        beam_blank_n,
    output logic [11:0]                 pt_x,
    output logic [11:0]                 pt_y,
    output logic                        pt_on,
    output logic                        pt_valid,
    input  logic                        pt_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  overflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_hiwater
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [15:0] H_OFF = 16'(H_CENTER);
    localparam logic signed [15:0] V_OFF = 16'(V_CENTER);

    function automatic logic [11:0] sat_code(input logic signed [15:0] off);
        logic signed [19:0] wide;
        wide = (20'(off) <<< SCALE_SHIFT) + 20'(DAC_MID);
        if (wide < 20'sd0)
            return 12'd0;
        if (wide > 20'sd4095)
            return 12'd4095;
        return wide[11:0];
    endfunction

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic                    vld_p0, vld_p1, vld_p2;
    logic [9:0]              h_p0, v_p0;
    logic                    on_p0, on_p1, on_p2;
    logic signed [15:0]      offx_p1, offy_p1;
    logic [11:0]             x_p2, y_p2;

    logic [11:0]             last_x, last_y;
    logic                    last_on, first_pt;
    logic [AW-1:0]           wr_ptr, rd_ptr, wr_addr;
    logic [LW-1:0]           level_next;
    logic [24:0]             fifo_mem [FIFO_DEPTH];
    logic [24:0]             head;
    logic                    moved, on_chg, want_push, full, pop;
    logic                    do_write, do_overwrite, upd_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= in_en;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 0: capture raw beam sample
    always_ff @(posedge clock) begin
        if (in_en) begin
            h_p0  <= beam_h;
            v_p0  <= beam_v;
            on_p0 <= beam_blank_n;
        end
    end

    // Stage 1: re-centre to signed offsets
    always_ff @(posedge clock) begin
        offx_p1 <= $signed({6'd0, h_p0}) - H_OFF;
        offy_p1 <= $signed({6'd0, v_p0}) - V_OFF;
        on_p1   <= on_p0;
    end

    // Stage 2: scale, add midpoint, saturate to DAC range
    always_ff @(posedge clock) begin
        x_p2  <= sat_code(offx_p1);
        y_p2  <= sat_code(offy_p1);
        on_p2 <= on_p1;
    end

    assign pop    = pt_valid & pt_ready;
    assign full   = (fifo_level == LW'(FIFO_DEPTH));
    assign on_chg = (on_p2 != last_on);
    assign moved  = (abs_diff(x_p2, last_x) >= 12'(MIN_DELTA)) ||
                    (abs_diff(y_p2, last_y) >= 12'(MIN_DELTA));
    assign want_push    = vld_p2 & (first_pt | moved | on_chg);
    assign do_write     = want_push & (~full | pop);
    // A blank-state transition must reach the DAC even when full, so it replaces the tail.
    assign do_overwrite = want_push & full & ~pop & on_chg;
    assign upd_last     = do_write | do_overwrite;
    assign wr_addr      = do_write ? wr_ptr : (wr_ptr - AW'(1));

    always_comb begin
        level_next = fifo_level;
        if (do_write && !pop)
            level_next = fifo_level + LW'(1);
        else if (!do_write && pop)
            level_next = fifo_level - LW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            first_pt   <= 1'b1;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= level_next;
            if (upd_last)
                first_pt <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (upd_last) begin
            last_x  <= x_p2;
            last_y  <= y_p2;
            last_on <= on_p2;
        end
        if (do_write || do_overwrite)
            fifo_mem[wr_addr] <= {on_p2, x_p2, y_p2};
    end

    assign head     = fifo_mem[rd_ptr];
    assign pt_valid = (fifo_level != '0);
    assign pt_on    = pt_valid ? head[24]    : 1'b0;
    assign pt_x     = pt_valid ? head[23:12] : 12'd0;
    assign pt_y     = pt_valid ? head[11:0]  : 12'd0;

`ifdef BEAM_DAC_STATS_EN
    logic          ovf_evt;
    logic [7:0]    ovf_q;
    logic [LW-1:0] hw_q;

    assign ovf_evt = want_push & full & ~pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= '0;
            hw_q  <= '0;
        end else begin
            if (ovf_evt && ovf_q != 8'hFF)
                ovf_q <= ovf_q + 8'd1;
            if (level_next > hw_q)
                hw_q <= level_next;
        end
    end

    assign overflow_cnt = ovf_q;
    assign fifo_hiwater = hw_q;
`else
    assign overflow_cnt = '0;
    assign fifo_hiwater = '0;
`endif

endmodule
